// File: rtl/axi4_rd_slave_resp.sv
// AXI4 read responder: AR accept, FIXED/INCR/WRAP address walk, 1-cycle
// memory reads, 2-entry R buffer with backpressure.
// Ports: aclk/aresetn; AR (arvalid, arready, arid, araddr, arlen, arsize,
// arburst); R (rvalid, rready, rid, rdata, rresp, rlast); memory
// (mem_rd_en, mem_rd_addr, mem_rd_data one cycle after mem_rd_en).
// Optional: `define AXI4_RD_SLAVE_4KB_CHK_EN flags INCR bursts that
// cross a 4KB boundary as SLVERR at accept.
module axi4_rd_slave_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int MAXSZ = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] B_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_SLV = 2'b10;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;

  // issue token travelling alongside the memory read
  logic                  inflight_q;
  logic [ID_WIDTH-1:0]   tok_id;
  logic                  tok_err;
  logic                  tok_last;

  // R buffer; entry 0 is always the head
  logic [ID_WIDTH-1:0]   f_id   [2];
  logic [DATA_WIDTH-1:0] f_data [2];
  logic [1:0]            f_resp [2];
  logic                  f_last [2];
  logic [1:0]            fifo_cnt;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_beat;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] sz_a;
  logic [ADDR_WIDTH-1:0] span_a;
  logic [ADDR_WIDTH-1:0] incr_a;
  logic [ADDR_WIDTH-1:0] wrap_a;
  logic                  wrap_len_ok;
  logic                  x4k;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] new_data;
  logic [1:0]            new_resp;

  assign arready = (state == IDLE);

  assign rvalid = (fifo_cnt != 2'd0);
  assign rid    = f_id[0];
  assign rdata  = f_data[0];
  assign rresp  = f_resp[0];
  assign rlast  = f_last[0];

  assign pop  = rvalid && rready;
  assign push = inflight_q;

  // buffered + in flight, net of this cycle's pop, must leave a free slot
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign issue = (state == BURST) &&
                 ((occ - {2'b00, pop}) < 3'd2);

  assign last_beat = (cnt_q == len_q);

  assign mem_rd_en   = issue && !err_q;
  assign mem_rd_addr = addr_q;

  assign new_data = tok_err ? '0 : mem_rd_data;
  assign new_resp = tok_err ? RESP_SLV : RESP_OK;

`ifdef AXI4_RD_SLAVE_4KB_CHK_EN
  logic [ADDR_WIDTH-1:0] sz_in;
  logic [ADDR_WIDTH-1:0] last_in;

  assign sz_in   = ADDR_WIDTH'(1) << arsize;
  assign last_in = (araddr & ~(sz_in - ADDR_WIDTH'(1))) +
                   (ADDR_WIDTH'(arlen) << arsize);
  assign x4k = (arburst == B_INCR) &&
               (araddr[ADDR_WIDTH-1:12] !=
                last_in[ADDR_WIDTH-1:12]);
`else
  assign x4k = 1'b0;
`endif

  assign wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) ||
                       (arlen == 8'd7) || (arlen == 8'd15);

  assign acc_err = (arburst == B_RSVD) ||
                   (arsize > 3'(MAXSZ)) ||
                   ((arburst == B_WRAP) && !wrap_len_ok) ||
                   x4k;

  always_comb begin
    sz_a   = ADDR_WIDTH'(1) << size_q;
    span_a = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    // only the first INCR beat may be unaligned
    incr_a = (addr_q & ~(sz_a - ADDR_WIDTH'(1))) + sz_a;
    wrap_a = (addr_q & ~(span_a - ADDR_WIDTH'(1))) |
             ((addr_q + sz_a) & (span_a - ADDR_WIDTH'(1)));
    next_addr = addr_q;
    unique case (1'b1)
      burst_q == B_INCR: next_addr = incr_a;
      burst_q == B_WRAP: next_addr = wrap_a;
      default:           next_addr = addr_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= B_FIXED;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arvalid) begin
            state   <= BURST;
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            cnt_q   <= '0;
            size_q  <= arsize;
            burst_q <= arburst;
            err_q   <= acc_err;
          end
        end
        BURST: begin
          if (issue) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q <= 1'b0;
      tok_id     <= '0;
      tok_err    <= 1'b0;
      tok_last   <= 1'b0;
    end else begin
      inflight_q <= issue;
      tok_id     <= id_q;
      tok_err    <= err_q;
      tok_last   <= last_beat;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_id[i]   <= '0;
        f_data[i] <= '0;
        f_resp[i] <= RESP_OK;
        f_last[i] <= 1'b0;
      end
    end else begin
      unique case ({push, pop})
        2'b10: begin
          f_id[fifo_cnt[0]]   <= tok_id;
          f_data[fifo_cnt[0]] <= new_data;
          f_resp[fifo_cnt[0]] <= new_resp;
          f_last[fifo_cnt[0]] <= tok_last;
          fifo_cnt            <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          f_id[0]   <= f_id[1];
          f_data[0] <= f_data[1];
          f_resp[0] <= f_resp[1];
          f_last[0] <= f_last[1];
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            f_id[0]   <= tok_id;
            f_data[0] <= new_data;
            f_resp[0] <= new_resp;
            f_last[0] <= tok_last;
          end else begin
            f_id[0]   <= f_id[1];
            f_data[0] <= f_data[1];
            f_resp[0] <= f_resp[1];
            f_last[0] <= f_last[1];
            f_id[1]   <= tok_id;
            f_data[1] <= new_data;
            f_resp[1] <= new_resp;
            f_last[1] <= tok_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
